// File: rtl/sad_window_accum.sv
// Streaming windowed sum of absolute pixel differences with saturation and a threshold match flag.
// Latency: last beat of a window accepted at edge T -> result valid after edge T+2.
// Backpressure: in_ready drops from the last accepted beat of a window until the result handshake.
module sad_window_accum #(
  parameter int PIX_W    = 16,
  parameter int CHANNELS = 3,
  parameter int WIN      = 11,
  parameter int SUM_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*PIX_W-1:0] in_cur,
  input  logic [CHANNELS*PIX_W-1:0] in_ref,
  input  logic [SUM_W-1:0]          threshold,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUM_W-1:0]          out_sum,
  output logic                      out_match,
  output logic                      out_sat
);

  // Per-beat sum width covers CHANNELS full-scale differences; the extended
  // accumulator sum is wide enough that nothing is lost before the overflow test.
  localparam int BW = PIX_W + $clog2(CHANNELS) + 1;
  localparam int EW = ((SUM_W > BW) ? SUM_W : BW) + 1;
  localparam int NBEATS = WIN * WIN;
  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBEATS - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             s1_vld_q, s1_last_q;
  logic [BW-1:0]    s1_sum_q, s1_sum_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             fin_q;
  logic             out_valid_q;
  logic [SUM_W-1:0] out_sum_q;
  logic             out_match_q, out_sat_q;

  logic             accept;
  logic             is_last;
  logic [PIX_W-1:0] cur_px, ref_px, diff_px;
  logic [EW-1:0]    sum_ext;
  logic             ovf;

  assign in_ready  = ~pending_q;
  assign accept    = in_valid & in_ready;
  assign is_last   = (cnt_q == CNT_LAST);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_match = out_match_q;
  assign out_sat   = out_sat_q;

  // Stage 1 datapath: absolute difference per channel, summed across channels.
  always_comb begin
    s1_sum_d = '0;
    cur_px   = '0;
    ref_px   = '0;
    diff_px  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cur_px   = in_cur[c*PIX_W +: PIX_W];
      ref_px   = in_ref[c*PIX_W +: PIX_W];
      diff_px  = (cur_px >= ref_px) ? (cur_px - ref_px) : (ref_px - cur_px);
      s1_sum_d = s1_sum_d + BW'(diff_px);
    end
  end

  // Beat counter and result-pending flag; pending is what throttles the input.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (accept) begin
      cnt_d = is_last ? '0 : cnt_q + CW'(1);
      if (is_last) pending_d = 1'b1;
    end
    if (out_valid_q && out_ready) pending_d = 1'b0;
  end

  // Stage 2 accumulator: saturate to all-ones on overflow and remember it for the window.
  always_comb begin
    sum_ext = EW'(acc_q) + EW'(s1_sum_q);
    ovf     = |sum_ext[EW-1:SUM_W];
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (fin_q) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (s1_vld_q) begin
      acc_d = ovf ? '1 : sum_ext[SUM_W-1:0];
      sat_d = sat_q | ovf;
    end
  end

  // Control and pipeline state; clear flushes everything reset does except the result value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      s1_vld_q  <= accept;
      s1_last_q <= accept & is_last;
      s1_sum_q  <= s1_sum_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      fin_q     <= s1_vld_q & s1_last_q;
      if (fin_q)                        out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready) out_valid_q <= 1'b0;
    end
  end

  // Result registers: loaded once per window, held until the next window completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sum_q   <= '0;
      out_match_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (fin_q && !clear) begin
      out_sum_q   <= acc_q;
      out_match_q <= (acc_q < threshold);
      out_sat_q   <= sat_q;
    end
  end

endmodule

// File: doc/sad_window_accum.md
Name: sad_window_accum

Overview:
- Streaming, parametrised successor to the combinational 3x11x11 pixel-difference summer.
- Accepts one window position per beat: CHANNELS pixel pairs (current, reference). Computes per-channel absolute differences, adds them across channels, and accumulates over WIN*WIN beats.
- Emits one saturated sum per window through a valid/ready handshake, plus a below-threshold match flag.
- Sits between the frame-buffer window reader and the motion/match decision logic.

Parameters:
- PIX_W, 16, bit width of each pixel sample (unsigned).
- CHANNELS, 3, colour channels per beat.
- WIN, 11, window edge; one window = WIN*WIN beats.
- SUM_W, 32, result width; must be at least PIX_W+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- clear  in  1  synchronous flush: aborts the current window and drops any pending result.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_cur  in  CHANNELS*PIX_W  current pixels; channel c at bits [c*PIX_W +: PIX_W].
- in_ref  in  CHANNELS*PIX_W  reference pixels, same packing.
- threshold  in  SUM_W  compare value; sampled when the result is produced.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SUM_W  window sum of absolute differences.
- out_match  out  1  out_sum < threshold.
- out_sat  out  1  accumulation saturated during this window.

Behaviour:
- Reset (reset=1 at an edge), all of these cleared:
  - beat counter=0, accumulator=0, pipeline valid=0;
  - out_valid=0, out_sum=0, out_match=0, out_sat=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Reset mid-window discards the partial sum; no result is emitted for that window.
- Beat accepted when in_valid & in_ready.
- Stage 1, registered:
  - d_c = |in_cur_c - in_ref_c|, unsigned, PIX_W bits.
  - beat_sum = sum over c of d_c, width PIX_W+clog2(CHANNELS)+1.
  - Also registers a "last" tag, set when the beat counter == WIN*WIN-1.
- Stage 2, accumulator:
  - acc += beat_sum, zero-extended to SUM_W.
  - If the true sum exceeds 2^SUM_W-1: acc holds all-ones and a sticky sat bit is set for the remainder of the window.
- Beat counter: increments per accepted beat; wraps from WIN*WIN-1 to 0.
- Latency: last beat accepted at edge T -> out_valid=1 after edge T+2. The result registers capture:
  - out_sum = final acc including that beat;
  - out_match = (final acc < threshold), with threshold sampled at that edge;
  - out_sat = sticky bit.
  - acc and sat are then zeroed for the next window.
- Result hold: out_sum, out_match and out_sat stay stable while out_valid=1 and out_ready=0. out_valid drops the cycle after out_valid & out_ready.
- Backpressure: in_ready = ~pending.
  - pending sets on the edge that accepts the last beat of a window.
  - pending clears on the edge where out_valid & out_ready.
  - So the first beat of the next window is accepted no earlier than the cycle after the result handshake.
  - Beats within a window may arrive back-to-back or with arbitrary in_valid gaps. Gaps do not affect the result.
- clear: same effect as reset on counter, acc, sat, pipeline, pending and out_valid. out_sum keeps its last value.
- Priority: reset > clear > normal operation.
- If clear coincides with an accepted beat, the beat is dropped.
- If clear coincides with an output handshake, the handshake is treated as completed.
- Arithmetic is fully unsigned; no truncation before the saturation check.

Test Plan:
- Defaults, 121 beats, every channel cur=10, ref=3, in_valid held high -> one result 2541 (7*3*121), out_sat=0, out_valid 2 cycles after the last beat; in_ready=0 until the handshake.
- cur<ref everywhere (cur=3, ref=10) -> 2541 (absolute value). Mixed: ch0 cur=0/ref=65535, others equal, 121 beats -> 7929735.
- SUM_W=17, all pairs 0/65535 -> out_sum=131071, out_sat=1. The next window with all-equal pixels -> 0, out_sat=0.
- threshold=2541 with the 2541 window -> out_match=0; threshold=2542 -> out_match=1. out_ready held low 5 cycles -> outputs stable, in_ready=0, extra in_valid beats not accepted.
- Random in_valid gaps (about 50% duty) over 3 consecutive windows -> sums equal a reference model; the beat counter wraps correctly.
- Assert clear after 60 beats, then feed a full window of 7-diff pixels -> only 2541 emitted. Assert reset while out_valid=1 -> out_valid=0 and out_sum=0 the next cycle.
